// File: rtl/i2c_txn_arbiter_if.sv
// Requester and byte-master signal bundle for the I2C transaction arbiter.
// The master modport is the arbiter side; the slave modport is requesters plus byte master.
interface i2c_txn_arbiter_if;
  logic [1:0] req, rw;
  logic [6:0] dev0, dev1;
  logic [7:0] wdata0, wdata1;
  logic [1:0] gnt, done;
  logic [7:0] rdata;
  logic       err;
  logic       cmd_valid, cmd_ready, cmd_start, cmd_stop, cmd_read;
  logic [7:0] cmd_wdata;
  logic       rsp_valid, rsp_nack;
  logic [7:0] rsp_rdata;

  modport master (
    input  req, rw, dev0, dev1, wdata0, wdata1, cmd_ready, rsp_valid, rsp_rdata, rsp_nack,
    output gnt, done, rdata, err, cmd_valid, cmd_start, cmd_stop, cmd_read, cmd_wdata
  );
  modport slave (
    output req, rw, dev0, dev1, wdata0, wdata1, cmd_ready, rsp_valid, rsp_rdata, rsp_nack,
    input  gnt, done, rdata, err, cmd_valid, cmd_start, cmd_stop, cmd_read, cmd_wdata
  );
endinterface

// File: rtl/i2c_txn_arbiter.sv
// Two-requester round-robin arbiter that runs one single-byte I2C transaction
// (START+address, data byte, STOP) at a time through a byte-level master.
module i2c_txn_arbiter #(
  parameter int TIMEOUT_CYC = 4096
) (
  input logic              clk,
  input logic              rst,
  i2c_txn_arbiter_if.master bus
);
  typedef enum logic [2:0] {
    IDLE, ADDR, ADDR_WAIT, DATA, DATA_WAIT, STOP, STOP_WAIT, DONE
  } state_t;

  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYC - 1);

  state_t      state, state_nxt;
  logic [1:0]  rst_sync;
  logic        run;
  logic [1:0]  gnt_q, pick;
  logic        last_one;
  logic        rw_q, err_q;
  logic [6:0]  dev_q;
  logic [7:0]  wdata_q, rdata_q;
  logic [15:0] cnt;
  logic        timeout, in_wait, grant, hs;
  logic        cv, cs, cp, cr;
  logic [7:0]  cw;

  // Assert asynchronously, release through two flops so the FSM first moves on edge 3.
  always_ff @(posedge clk or negedge rst)
    if (!rst) rst_sync <= '0;
    else      rst_sync <= {rst_sync[0], 1'b1};
  assign run = rst_sync[1];

  assign timeout = (cnt == TO_LAST);
  assign in_wait = (state == ADDR_WAIT) || (state == DATA_WAIT) || (state == STOP_WAIT);
  assign hs      = cv && bus.cmd_ready;
  assign grant   = (state == IDLE) && (state_nxt == ADDR);

  // last_one=1 means requester 1 won last, so requester 0 is favoured.
  always_comb begin
    pick = 2'b00;
    if (bus.req[0] && (!bus.req[1] || last_one)) pick = 2'b01;
    else if (bus.req[1])                         pick = 2'b10;
  end

  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else      state <= state_nxt;

  always_comb begin
    state_nxt = state;
    cv = 1'b0; cs = 1'b0; cp = 1'b0; cr = 1'b0; cw = 8'h00;
    case (state)
      IDLE:      if (run && |bus.req) state_nxt = ADDR;
      ADDR: begin
        cv = 1'b1; cs = 1'b1; cw = {dev_q, rw_q};
        if (hs) state_nxt = ADDR_WAIT;
      end
      ADDR_WAIT: if (bus.rsp_valid) state_nxt = bus.rsp_nack ? STOP : DATA;
                 else if (timeout)  state_nxt = STOP;
      DATA: begin
        cv = 1'b1; cr = rw_q; cw = rw_q ? 8'h00 : wdata_q;
        if (hs) state_nxt = DATA_WAIT;
      end
      DATA_WAIT: if (bus.rsp_valid || timeout) state_nxt = STOP;
      STOP: begin
        cv = 1'b1; cp = 1'b1;
        if (hs) state_nxt = STOP_WAIT;
      end
      STOP_WAIT: if (bus.rsp_valid || timeout) state_nxt = DONE;
      DONE:      state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      gnt_q <= '0; last_one <= 1'b1; rw_q <= 1'b0; dev_q <= '0;
      wdata_q <= '0; rdata_q <= '0; err_q <= 1'b0; cnt <= '0;
    end else begin
      if (grant) begin
        gnt_q    <= pick;
        last_one <= pick[1];
        rw_q     <= pick[1] ? bus.rw[1] : bus.rw[0];
        dev_q    <= pick[1] ? bus.dev1 : bus.dev0;
        wdata_q  <= pick[1] ? bus.wdata1 : bus.wdata0;
        rdata_q  <= '0;
        err_q    <= 1'b0;
      end else if (state == DONE) begin
        gnt_q <= '0;
      end
      // Counter is zero outside the wait states, so every wait entry starts from 0.
      cnt <= in_wait ? cnt + 16'd1 : '0;
      case (state)
        ADDR_WAIT: if (bus.rsp_valid ? bus.rsp_nack : timeout) err_q <= 1'b1;
        DATA_WAIT:
          if (bus.rsp_valid) begin
            if (rw_q) rdata_q <= bus.rsp_rdata;
            if (bus.rsp_nack && !rw_q) err_q <= 1'b1;
          end else if (timeout) err_q <= 1'b1;
        STOP_WAIT: if (!bus.rsp_valid && timeout) err_q <= 1'b1;
        default: ;
      endcase
    end

  assign bus.gnt       = gnt_q;
  assign bus.done      = (state == DONE) ? gnt_q : 2'b00;
  assign bus.err       = (state == DONE) && err_q;
  assign bus.rdata     = (state == DONE) ? rdata_q : 8'h00;
  assign bus.cmd_valid = cv;
  assign bus.cmd_start = cs;
  assign bus.cmd_stop  = cp;
  assign bus.cmd_read  = cr;
  assign bus.cmd_wdata = cw;
endmodule

// File: tb/tb_i2c_txn_arbiter.sv
// Randomized bench for i2c_txn_arbiter: a byte-master responder plus a
// transaction-level model of grant order, command list, err and rdata.
module tb_i2c_txn_arbiter;
  localparam int TO = 16;

  logic clk, rst;
  int   cyc = 0;
  int   npass = 0, ntot = 0;

  i2c_txn_arbiter_if bus ();
  i2c_txn_arbiter #(.TIMEOUT_CYC(TO)) dut (.clk(clk), .rst(rst), .bus(bus));

  initial begin clk = 1'b0; forever #5 clk = ~clk; end
  always @(posedge clk) cyc <= cyc + 1;

  // per-requester transaction config; drop: 0/1/2 = no response to addr/data/stop, 3 = none dropped
  logic       c_rw[2], c_na[2], c_nd[2];
  logic [6:0] c_dev[2];
  logic [7:0] c_wd[2], c_byte[2];
  int         c_drop[2];

  logic [10:0] obs[$];        // {start, stop, read, wdata} per handshake
  logic [10:0] last_obs[$];
  logic [1:0]  gseq[$];
  logic [1:0]  last_done;
  logic        last_err;
  logic [7:0]  last_rd;
  int          hs_cyc[3];
  logic        last_g;        // 1: requester 1 granted last

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    ntot++;
    assert (o === e) npass++;
    else $error("FAIL %s: got %0h expected %0h", tag, o, e);
  endtask

  // Byte-master model: random ready, 0-3 cycle response latency, stray pulses outside waits.
  initial begin
    logic pend; int dly, pidx, r;
    pend = 1'b0; dly = 0; pidx = 0;
    bus.cmd_ready = 1'b0; bus.rsp_valid = 1'b0; bus.rsp_nack = 1'b0; bus.rsp_rdata = 8'h00;
    forever begin
      @(negedge clk);
      if (rst && bus.cmd_valid && bus.cmd_ready) begin
        obs.push_back({bus.cmd_start, bus.cmd_stop, bus.cmd_read, bus.cmd_wdata});
        pidx = bus.cmd_start ? 0 : (bus.cmd_stop ? 2 : 1);
        hs_cyc[pidx] = cyc;
        pend = 1'b1;
        dly = $urandom_range(0, 3);
      end
      @(posedge clk); #1;
      r = bus.gnt[1] ? 1 : 0;
      bus.rsp_valid = 1'b0;
      bus.rsp_nack  = 1'($urandom);
      bus.rsp_rdata = 8'($urandom);
      if (!rst) pend = 1'b0;
      else if (pend) begin
        if (dly == 0) begin
          pend = 1'b0;
          if (c_drop[r] != pidx) begin
            bus.rsp_valid = 1'b1;
            bus.rsp_rdata = c_byte[r];
            if (pidx == 0) bus.rsp_nack = c_na[r];
            else if (pidx == 1) bus.rsp_nack = c_nd[r];
          end
        end else dly--;
      end else if (bus.cmd_valid && $urandom_range(0, 3) == 0) bus.rsp_valid = 1'b1;
      bus.cmd_ready = ($urandom_range(0, 2) != 0);
    end
  end

  task automatic set_cfg(input int i, input logic rw, input logic [6:0] dev, input logic [7:0] wd,
                         input logic na, input logic nd, input int drop, input logic [7:0] b);
    c_rw[i] = rw; c_dev[i] = dev; c_wd[i] = wd; c_na[i] = na; c_nd[i] = nd;
    c_drop[i] = drop; c_byte[i] = b;
  endtask

  task automatic new_cfg(input int i);
    int d;
    d = $urandom_range(0, 9);
    set_cfg(i, 1'($urandom), 7'($urandom), 8'($urandom), $urandom_range(0, 3) == 0,
            $urandom_range(0, 3) == 0, (d < 3) ? d : 3, 8'($urandom));
  endtask

  task automatic drive(input int i);
    bus.rw[i] = c_rw[i];
    if (i == 0) begin bus.dev0 = c_dev[0]; bus.wdata0 = c_wd[0]; end
    else        begin bus.dev1 = c_dev[1]; bus.wdata1 = c_wd[1]; end
  endtask

  task automatic outs_zero(input string tag);
    chk(tag, {bus.gnt, bus.done, bus.err, bus.rdata, bus.cmd_valid, bus.cmd_start,
              bus.cmd_stop, bus.cmd_read, bus.cmd_wdata}, 32'h0);
  endtask

  task automatic do_reset();
    rst = 1'b0; bus.req = 2'b00; last_g = 1'b1;
    repeat (3) @(posedge clk);
    #1 outs_zero("reset_outs");
    @(negedge clk); rst = 1'b1;
    obs.delete();
  endtask

  // Runs n0/n1 back-to-back transactions per requester and checks each against the model.
  task automatic run(input int n0, input int n1, input logic rand_first, input int budget);
    int rem[2]; int used, cur, stop_c, dd;
    logic in_txn, act_grant, act_done, gap;
    logic [1:0] g, pr, eg;
    logic [10:0] ec[$];
    logic s_rw, s_nd, addr_ok, e_err;
    logic [7:0] e_rd;
    rem[0] = n0; rem[1] = n1; used = 0; cur = 0; stop_c = -1; dd = 3;
    in_txn = 1'b0; gap = 1'b0; g = 2'b00; e_err = 1'b0; e_rd = 8'h00; addr_ok = 1'b0;
    for (int i = 0; i < 2; i++)
      if (rem[i] > 0) begin
        if (rand_first) new_cfg(i);
        drive(i);
        bus.req[i] = 1'b1;
      end
    while ((rem[0] > 0 || rem[1] > 0 || in_txn) && used < budget) begin
      @(negedge clk); used++;
      act_grant = 1'b0; act_done = 1'b0;
      if (gap) begin chk("idle_gap", bus.gnt, 2'b00); gap = 1'b0; end
      else if (!in_txn && bus.gnt != 2'b00) begin
        pr = bus.req;
        eg = (pr == 2'b11) ? (last_g ? 2'b01 : 2'b10) : pr;
        chk("grant", bus.gnt, eg);
        g = bus.gnt; cur = g[1] ? 1 : 0; last_g = g[1]; gseq.push_back(g);
        s_rw = c_rw[cur]; s_nd = c_nd[cur]; dd = c_drop[cur];
        addr_ok = (dd != 0) && !c_na[cur];
        ec.delete();
        ec.push_back({3'b100, c_dev[cur], s_rw});
        if (addr_ok) ec.push_back({2'b00, s_rw, s_rw ? 8'h00 : c_wd[cur]});
        ec.push_back({3'b010, 8'h00});
        e_err = (dd == 0) || (dd == 2) || (dd != 0 && c_na[cur]) ||
                (addr_ok && (dd == 1 || (!s_rw && s_nd)));
        e_rd = (addr_ok && s_rw && dd != 1) ? c_byte[cur] : 8'h00;
        in_txn = 1'b1; stop_c = -1; act_grant = 1'b1;
      end
      if (in_txn && bus.cmd_valid && bus.cmd_stop && stop_c < 0) stop_c = cyc;
      if (in_txn && bus.done != 2'b00) begin
        chk("done", bus.done, g);
        chk("gnt_held", bus.gnt, g);
        chk("err", bus.err, e_err);
        chk("rdata", bus.rdata, e_rd);
        chk("ncmd", obs.size(), ec.size());
        for (int k = 0; k < obs.size() && k < ec.size(); k++)
          if (ec[k][9]) chk("cmd_stop", obs[k][10:8], ec[k][10:8]);
          else          chk("cmd", obs[k], ec[k]);
        if (dd == 0 || (dd == 1 && addr_ok)) chk("timeout_gap", stop_c - hs_cyc[dd] - 1, TO);
        last_obs = obs; last_done = bus.done; last_err = bus.err; last_rd = bus.rdata;
        obs.delete();
        rem[cur]--; in_txn = 1'b0; act_done = 1'b1; gap = 1'b1;
      end
      @(posedge clk); #1;
      if (act_grant) begin
        // scramble the granted requester's inputs; the latched copy must be used
        bus.rw[cur] = 1'($urandom);
        if (cur == 0) begin bus.dev0 = 7'($urandom); bus.wdata0 = 8'($urandom); end
        else          begin bus.dev1 = 7'($urandom); bus.wdata1 = 8'($urandom); end
        if (rem[cur] == 1 && $urandom_range(0, 3) == 0) bus.req[cur] = 1'b0;
      end
      if (act_done) begin
        if (rem[cur] > 0) begin new_cfg(cur); drive(cur); bus.req[cur] = 1'b1; end
        else bus.req[cur] = 1'b0;
      end
    end
    chk("run_in_budget", used < budget, 1'b1);
  endtask

  initial begin
    int w;
    rst = 1'b0; bus.req = 2'b00; bus.rw = 2'b00;
    bus.dev0 = '0; bus.dev1 = '0; bus.wdata0 = '0; bus.wdata1 = '0;
    for (int i = 0; i < 2; i++) set_cfg(i, 1'b0, 7'h0, 8'h0, 1'b0, 1'b0, 3, 8'h0);
    do_reset();

    // single write, with reset-release synchronization check
    rst = 1'b0;
    set_cfg(0, 1'b0, 7'h50, 8'hA5, 1'b0, 1'b0, 3, 8'h00); drive(0); bus.req = 2'b01;
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1 chk("sync_release", bus.gnt, 2'b00);
    run(1, 0, 1'b0, 300);
    chk("w_addr", last_obs[0][7:0], 8'hA0);
    chk("w_data", last_obs[1][7:0], 8'hA5);
    chk("w_done", last_done, 2'b01);
    chk("w_err", last_err, 1'b0);
    chk("w_rdata", last_rd, 8'h00);

    // single read
    set_cfg(1, 1'b1, 7'h50, 8'h77, 1'b0, 1'b0, 3, 8'h3C);
    run(0, 1, 1'b0, 300);
    chk("r_addr", last_obs[0][7:0], 8'hA1);
    chk("r_read", last_obs[1][8], 1'b1);
    chk("r_done", last_done, 2'b10);
    chk("r_rdata", last_rd, 8'h3C);
    chk("r_err", last_err, 1'b0);

    // address NACK: START then STOP only
    set_cfg(0, 1'b0, 7'h21, 8'h11, 1'b1, 1'b0, 3, 8'h00);
    run(1, 0, 1'b0, 300);
    chk("nack_ncmd", last_obs.size(), 2);
    chk("nack_stop", last_obs[1][9], 1'b1);
    chk("nack_err", last_err, 1'b1);

    // data response never arrives
    set_cfg(0, 1'b0, 7'h33, 8'h44, 1'b0, 1'b0, 1, 8'h00);
    run(1, 0, 1'b0, 300);
    chk("to_err", last_err, 1'b1);

    // reset while in DATA_WAIT, then a clean transaction
    set_cfg(0, 1'b0, 7'h22, 8'h5A, 1'b0, 1'b0, 1, 8'h00); drive(0); bus.req = 2'b01;
    w = 0;
    while (obs.size() < 2 && w < 200) begin @(negedge clk); w++; end
    chk("mid_reach", w < 200, 1'b1);
    @(posedge clk); #3 rst = 1'b0;
    #1 outs_zero("mid_rst_outs");
    bus.req = 2'b00; last_g = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 1'b1; obs.delete();
    set_cfg(0, 1'b0, 7'h22, 8'h5A, 1'b0, 1'b0, 3, 8'h00);
    run(1, 0, 1'b0, 300);
    chk("post_rst_done", last_done, 2'b01);
    chk("post_rst_err", last_err, 1'b0);

    // contention straight out of reset
    do_reset();
    set_cfg(0, 1'b0, 7'h10, 8'h01, 1'b0, 1'b0, 3, 8'h00);
    set_cfg(1, 1'b1, 7'h11, 8'h02, 1'b0, 1'b0, 3, 8'h99);
    gseq.delete();
    run(2, 1, 1'b0, 600);
    chk("rr_n", gseq.size(), 3);
    if (gseq.size() == 3) begin
      chk("rr_0", gseq[0], 2'b01);
      chk("rr_1", gseq[1], 2'b10);
      chk("rr_2", gseq[2], 2'b01);
    end

    for (int r = 0; r < 40; r++)
      run($urandom_range(0, 2), $urandom_range(0, 2), 1'b1, 800);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule

// File: doc/i2c_txn_arbiter.md
I2C_TXN_ARBITER -- requirements
Module: i2c_txn_arbiter

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CYC, default 4096, giving the maximum clk cycles to wait for one byte-master response before aborting.
REQ-002 The block SHALL have port clk, input, 1, system clock; all logic is rising-edge.
REQ-003 The block SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-004 The block SHALL have ports req[1:0], input, 2, per-requester transaction request; held high until that requester's done pulse.
REQ-005 The block SHALL have ports rw[1:0], input, 2, per-requester direction: 1 = read, 0 = write.
REQ-006 The block SHALL have ports dev0 and dev1, input, 7 each, 7-bit I2C device address per requester.
REQ-007 The block SHALL have ports wdata0 and wdata1, input, 8 each, write byte per requester.
REQ-008 The block SHALL have port gnt, output, 2, one-hot grant; it is zero when idle.
REQ-009 The block SHALL have port done, output, 2, one-cycle completion pulse to the granted requester.
REQ-010 The block SHALL have ports rdata (output, 8) and err (output, 1); both are valid only in the cycle done is nonzero.
REQ-011 The block SHALL have the following byte-master command ports: cmd_valid (output, 1), cmd_ready (input, 1), cmd_start (output, 1), cmd_stop (output, 1), cmd_read (output, 1) and cmd_wdata (output, 8).
REQ-012 The block SHALL have the following byte-master response ports: rsp_valid (input, 1) as a one-cycle pulse, rsp_rdata (input, 8) and rsp_nack (input, 1).

Function
REQ-013 Arbitration SHALL be round-robin and evaluated only in IDLE:
- if both requesters are pending, grant goes to the one not granted last;
- after reset, requester 0 has priority.
REQ-014 Requester inputs (rw, dev, wdata) SHALL be latched in the grant cycle and held stable internally for the whole transaction.
REQ-015 The state machine SHALL have states IDLE, ADDR, ADDR_WAIT, DATA, DATA_WAIT, STOP, STOP_WAIT, DONE.
REQ-016 IDLE -> ADDR SHALL occur one cycle after any req bit is seen high; gnt asserts in that same cycle and is held until DONE exits.
REQ-017 ADDR SHALL issue cmd_valid=1, cmd_start=1, cmd_read=0, cmd_wdata={dev,rw}; it stays until cmd_ready=1 is seen with cmd_valid=1, then goes to ADDR_WAIT.
REQ-018 ADDR_WAIT SHALL behave as follows on rsp_valid:
- rsp_nack=1 -> STOP with error flag set;
- otherwise -> DATA.
REQ-019 DATA SHALL issue cmd_valid=1, cmd_start=0, cmd_read=rw, cmd_wdata=wdata (write) or 0 (read), then move to DATA_WAIT on handshake.
REQ-020 DATA_WAIT SHALL behave as follows on rsp_valid:
- capture rsp_rdata when rw=1;
- set the error flag when rsp_nack=1 and rw=0; a read NACK is master-generated and is not an error;
- then go to STOP.
REQ-021 STOP SHALL issue cmd_valid=1, cmd_stop=1, cmd_start=0, cmd_read=0, then go to STOP_WAIT on handshake.
REQ-022 STOP_WAIT SHALL go to DONE on rsp_valid; rsp_nack is ignored there.
REQ-023 DONE SHALL last exactly one cycle and then return to IDLE:
- done[granted]=1;
- err = error flag;
- rdata = captured byte, or 0 for writes.
REQ-024 cmd_valid SHALL be 1 only in ADDR, DATA and STOP, and cmd_* fields SHALL be stable while cmd_valid=1 and cmd_ready=0.
REQ-025 Timeout handling SHALL work as follows:
- a 16-bit counter resets on each *_WAIT entry and increments each cycle in *_WAIT;
- reaching TIMEOUT_CYC in ADDR_WAIT or DATA_WAIT sets the error flag and goes to STOP;
- reaching TIMEOUT_CYC in STOP_WAIT sets the error flag and goes to DONE.
REQ-026 A requester dropping req mid-transaction SHALL NOT abort the transaction; the transaction completes and done still pulses.
REQ-027 rsp_valid outside the *_WAIT states SHALL be ignored.
REQ-028 A req asserted in the DONE cycle SHALL be arbitrated in the following IDLE cycle, so transactions are separated by at least one idle cycle.

Reset
REQ-029 When rst=0, the block SHALL asynchronously force the following:
- state to IDLE;
- gnt, done, err, rdata, cmd_valid, cmd_start, cmd_stop, cmd_read and cmd_wdata to 0;
- timeout counter to 0;
- round-robin pointer to favour requester 0.
REQ-030 Reset asserted mid-transaction SHALL abandon the transaction without issuing STOP or done; the byte master is reset by the same rst.
REQ-031 Reset release SHALL be synchronized so that the first state change occurs no earlier than the second rising clk edge after rst rises.

Verification
REQ-032 Single write: req0=1, rw0=0, dev0=7'h50, wdata0=8'hA5, with a responder that ACKs everything -> commands are START/8'hA0, then 8'hA5, then STOP; done=2'b01, err=0, rdata=0.
REQ-033 Single read: req1=1, rw1=1, dev1=7'h50, responder returns rsp_rdata=8'h3C -> address byte 8'hA1, data command with cmd_read=1; done=2'b10, rdata=8'h3C, err=0.
REQ-034 Address NACK: responder NACKs the address byte -> no data command is issued, STOP is issued, and done pulses with err=1.
REQ-035 Contention: req0 and req1 asserted together, held until done -> grants are 01 then 10 then 01, and neither requester is granted twice in a row.
REQ-036 Timeout: TIMEOUT_CYC=16 and no rsp_valid after DATA -> STOP is issued 16 cycles after DATA_WAIT entry, and done pulses with err=1.
REQ-037 Mid-transaction reset: rst=0 during DATA_WAIT -> all outputs are 0 immediately; a subsequent req0 completes normally.
